// File: rtl/bus_pkg.sv
// Shared bus definitions: state encoding, strobe levels, default widths and the
// per-state control decode used by the initiator and the responder models.
package bus_pkg;

   localparam int DEF_ADDR_W   = 20;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_MAX_WAIT = 7;

   localparam logic STROBE_OFF = 1'b1;
   localparam logic STROBE_ON  = 1'b0;

   typedef enum logic [2:0] {
      TI = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      TW = 3'd4,
      T4 = 3'd5
   } bus_state_t;

   typedef struct packed {
      logic ale;
      logic rd;
      logic wr;
      logic drive;
      logic req_ready;
   } bus_ctl_t;

   // Control levels the bus must show while sitting in state st.
   function automatic bus_ctl_t ctl_for(input bus_state_t st, input logic write);
      bus_ctl_t c;
      c = '{ale: 1'b0, rd: STROBE_OFF, wr: STROBE_OFF, drive: 1'b0, req_ready: 1'b0};
      case (st)
         TI, T4: c.req_ready = 1'b1;
         T1:     c.ale = 1'b1;
         T2, T3, TW: begin
            if (write) begin
               c.wr    = STROBE_ON;
               c.drive = 1'b1;
            end else begin
               c.rd = STROBE_ON;
            end
         end
         default: c.req_ready = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/bus_cycle_initiator_if.sv
// Core request/response handshake and multiplexed system bus control lines.
// The tri-state Data lines travel as a separate port of the initiator.
interface bus_cycle_initiator_if #(
   parameter int ADDR_W = bus_pkg::DEF_ADDR_W,
   parameter int DATA_W = bus_pkg::DEF_DATA_W
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_iom;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              ALE;
   logic              RD;
   logic              WR;
   logic              IOM;
   logic [ADDR_W-1:0] Address;
   logic              READY;

   modport master (
      input  req_valid, req_write, req_iom, req_addr, req_wdata, READY,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output ALE, RD, WR, IOM, Address
   );

   modport slave (
      output req_valid, req_write, req_iom, req_addr, req_wdata, READY,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  ALE, RD, WR, IOM, Address
   );
endinterface

// File: rtl/bus_cycle_initiator_wait_timer.sv
// Wait-state counter: clears, counts enabled cycles and flags the enabled
// cycle that is the MAX_WAIT-th one since the last clear.
module wait_timer #(
   parameter int MAX_WAIT = bus_pkg::DEF_MAX_WAIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] count_r;

   // Counter register: clear has priority over enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         count_r <= {CNT_W{1'b0}};
      end else if (en) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign done = en && (count_r == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/bus_cycle_initiator.sv
// 8088-style bus cycle initiator sequencing T1-T4 for one core request at a time.
// Define WAIT_STATE_EN to honour READY with TW wait states and a MAX_WAIT timeout.
module bus_cycle_initiator
   import bus_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   bus_cycle_initiator_if.master   bus,
   inout  wire  [DATA_W-1:0]       Data
);

   bus_state_t        state_r;
   bus_state_t        state_nxt_s;
   bus_ctl_t          ctl_nxt_s;
   logic              hs_s;
   logic              write_r;
   logic              write_nxt_s;
   logic [DATA_W-1:0] wdata_r;
   logic              data_oe_r;
   logic              timeout_s;
   logic              capture_s;

`ifdef WAIT_STATE_EN
   logic wait_done_s;

   wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk   (CLK),
      .rst_n (RESET_N),
      .clr   (state_r == T3),
      .en    (state_r == TW),
      .done  (wait_done_s)
   );

   // Forced exit: the limit is reached while the responder is still not ready.
   assign timeout_s = (state_r == TW) && wait_done_s && !bus.READY;
`else
   logic ready_unused_s;
   localparam int MAX_WAIT_UNUSED = MAX_WAIT;

   assign ready_unused_s = bus.READY;
   assign timeout_s      = 1'b0;
`endif

   assign hs_s        = bus.req_valid && bus.req_ready;
   assign write_nxt_s = hs_s ? bus.req_write : write_r;

   // Next-state selection for the T-state sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         TI: begin
            if (hs_s) state_nxt_s = T1;
            else      state_nxt_s = TI;
         end
         T1: state_nxt_s = T2;
         T2: state_nxt_s = T3;
`ifdef WAIT_STATE_EN
         T3: begin
            if (bus.READY) state_nxt_s = T4;
            else           state_nxt_s = TW;
         end
         TW: begin
            if (bus.READY || wait_done_s) state_nxt_s = T4;
            else                          state_nxt_s = TW;
         end
`else
         T3: state_nxt_s = T4;
         TW: state_nxt_s = T4;
`endif
         T4: begin
            if (hs_s) state_nxt_s = T1;
            else      state_nxt_s = TI;
         end
         default: state_nxt_s = TI;
      endcase
   end

   // Outputs are registered from the next state so they change with the state.
   assign ctl_nxt_s = ctl_for(state_nxt_s, write_nxt_s);
   assign capture_s = ((state_r == T3) || (state_r == TW)) && (state_nxt_s == T4) && !write_r;

   // Sequencer state, latched request and all registered bus/response outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r       <= TI;
         write_r       <= 1'b0;
         wdata_r       <= {DATA_W{1'b0}};
         data_oe_r     <= 1'b0;
         bus.ALE       <= 1'b0;
         bus.RD        <= STROBE_OFF;
         bus.WR        <= STROBE_OFF;
         bus.IOM       <= 1'b0;
         bus.Address   <= {ADDR_W{1'b0}};
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= {DATA_W{1'b0}};
         bus.rsp_err   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (hs_s) begin
            write_r     <= bus.req_write;
            wdata_r     <= bus.req_wdata;
            bus.IOM     <= bus.req_iom;
            bus.Address <= bus.req_addr;
         end else begin
            write_r     <= write_r;
            wdata_r     <= wdata_r;
            bus.IOM     <= bus.IOM;
            bus.Address <= bus.Address;
         end
         bus.ALE       <= ctl_nxt_s.ale;
         bus.RD        <= ctl_nxt_s.rd;
         bus.WR        <= ctl_nxt_s.wr;
         data_oe_r     <= ctl_nxt_s.drive;
         bus.req_ready <= ctl_nxt_s.req_ready;
         bus.rsp_valid <= (state_nxt_s == T4);
         bus.rsp_err   <= (state_nxt_s == T4) && timeout_s;
         if (capture_s) begin
            bus.rsp_rdata <= Data;
         end else begin
            bus.rsp_rdata <= bus.rsp_rdata;
         end
      end
   end

   assign Data = data_oe_r ? wdata_r : {DATA_W{1'bz}};

endmodule
